slave_fifo: RTL
===============

# slave_fifo

Parametrised successor to the single-register handshake slave. It accepts beats on an upstream valid/ready interface into a DEPTH-entry first-word-fall-through FIFO and presents them on a downstream valid/ready interface. Upstream `ready` stays registered and is gated by `ready_en`, as in the single-register slave, and additionally by FIFO space. The block sits between a handshake master and a consumer that may stall.

## Interface
- `WIDTH`, default 8: data width in bits; must be ≥ 1.
- `DEPTH`, default 4: FIFO entries; must be a power of two and ≥ 2.
- Derived: `AW = $clog2(DEPTH)` is the pointer width; `CW = AW+1` is the count width.

- `clk`  in  1  sole clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `ready_en`  in  1  upstream-acceptance enable.
- `valid`  in  1  upstream beat valid.
- `sdata_in`  in  WIDTH  upstream data.
- `ready`  out  1  registered upstream ready.
- `sdata_out`  out  WIDTH  head-of-FIFO data.
- `out_valid`  out  1  head entry valid.
- `out_ready`  in  1  downstream accepts the head entry.
- `count`  out  CW  occupancy, 0..DEPTH; present only with `SLAVE_FIFO_COUNT_EN`.

## Operation
- Push: when `valid && ready` at a rising edge, write `sdata_in` to `mem[wptr]` and increment `wptr` modulo DEPTH.
- Pop: when `out_valid && out_ready` at a rising edge, increment `rptr` modulo DEPTH.
- `sdata_out = mem[rptr]` is combinational from the storage (first-word fall-through).
- `out_valid = (occ != 0)`.
- Occupancy `occ` (CW bits) updates as follows:
  - +1 on push only.
  - −1 on pop only.
  - Unchanged on simultaneous push and pop, or when neither occurs.
- `ready` is registered: `ready <= ready_en && (occ_next < DEPTH)`, where `occ_next` is the post-edge occupancy. This guarantees that a push is never offered when the FIFO has no space.
- Full (`occ == DEPTH`):
  - `ready` is 0 in that cycle.
  - A pop in that cycle makes `ready` 1 in the next cycle, if `ready_en` is high.
- Empty (`occ == 0`):
  - `out_valid` is 0; `out_ready` is ignored.
  - A push in the same cycle is not bypassed to the output.
- Simultaneous push and pop at any non-empty, non-full occupancy: both pointers advance and `occ` is unchanged.
- Deasserting `ready_en` drops `ready` one cycle later. The data already in the FIFO continues to drain.
- `valid` without `ready`: no write occurs. The master is expected to hold its data; the block does not check this.
- Reset (asynchronous, at any time including mid-transfer):
  - `wptr`, `rptr` and `occ` go to 0.
  - `ready` = 0, `out_valid` = 0, and `count` = 0 when present.
  - `mem` is not reset. `sdata_out` is undefined while `out_valid` = 0, and benches must not check it then.
- After `rst_n` rises, `ready` follows `ready_en` from the first clock edge onward.

## Timing
- Upstream accept to `out_valid` high: 1 cycle (written at edge N, visible after edge N).
- Pop to next head on `sdata_out`: visible immediately after the pop edge.
- `ready` reacts 1 cycle after a change in `ready_en` or in occupancy.
- Sustained throughput is 1 beat per cycle while `ready_en` = 1 and `out_ready` = 1.
- With `out_ready` = 0, exactly DEPTH beats are accepted; `ready` falls at the edge that completes the DEPTH-th push.
- No combinational path from `out_ready` to `ready`. The only combinational outputs are `sdata_out` (from `rptr`) and `out_valid` (from `occ`).

## Configuration
- `SLAVE_FIFO_COUNT_EN` defined:
  - The `count` output port exists and is driven by `occ`.
  - `count` is reset to 0.
- `SLAVE_FIFO_COUNT_EN` undefined:
  - The `count` port is absent.
  - `occ` remains internal; all other behaviour is identical.

## Test plan
- Reset release, `ready_en` = 1, `valid` = 0 → `ready` = 0 during reset; `ready` = 1 after the first edge; `out_valid` = 0.
- WIDTH = 8, DEPTH = 4, `out_ready` = 0, push 0x11, 0x22, 0x33, 0x44, 0x55 back-to-back:
  - First four are accepted; `ready` = 0 after the 4th; 0x55 is held off.
  - `sdata_out` = 0x11; `count` = 4.
- From full, pulse `out_ready` for one cycle → 0x11 popped; `sdata_out` = 0x22; `ready` = 1 on the next cycle; 0x55 accepted; `count` returns to 4.
- Streaming: `ready_en` = 1, `out_ready` = 1, `valid` held for 10 beats with values 0x00..0x09:
  - Beats appear in order, one per cycle, after 1 cycle of latency.
  - `count` stays ≤ 1.
- `ready_en` dropped with 2 entries queued → `ready` = 0 one cycle later; both entries still drain in order with `out_ready` = 1; `out_valid` then falls to 0.
- Assert `rst_n` = 0 asynchronously mid-stream with 3 entries queued → `out_valid`, `ready` and `count` go to 0 immediately, without waiting for a clock edge; no stale beat appears after reset is released.

Source files
------------

// File: rtl/slave_fifo.sv
// slave_fifo: valid/ready slave feeding a DEPTH-entry first-word-fall-through FIFO.
// Define SLAVE_FIFO_COUNT_EN to expose the occupancy on the count port.
module slave_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     ready_en,
    input  logic                     valid,
    input  logic [WIDTH-1:0]         sdata_in,
    output logic                     ready,
    output logic [WIDTH-1:0]         sdata_out,
    output logic                     out_valid,
    input  logic                     out_ready
`ifdef SLAVE_FIFO_COUNT_EN
    ,
    output logic [$clog2(DEPTH):0]   count
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr;
    logic [AW-1:0]    rptr;
    logic [CW-1:0]    occ;
    logic [CW-1:0]    occ_next;
    logic             push;
    logic             pop;

    assign out_valid = (occ != '0);
    assign sdata_out = mem[rptr];
    assign push      = valid && ready;
    assign pop       = out_valid && out_ready;

    always_comb begin
        occ_next = occ;
        unique case ({push, pop})
            2'b10:   occ_next = occ + CW'(1);
            2'b01:   occ_next = occ - CW'(1);
            default: occ_next = occ;
        endcase
    end

    // Storage is deliberately left unreset; only the pointers define validity.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wptr] <= sdata_in;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr  <= '0;
            rptr  <= '0;
            occ   <= '0;
            ready <= 1'b0;
        end else begin
            if (push) begin
                wptr <= wptr + AW'(1);
            end
            if (pop) begin
                rptr <= rptr + AW'(1);
            end
            occ   <= occ_next;
            ready <= ready_en && (occ_next < CW'(DEPTH));
        end
    end

`ifdef SLAVE_FIFO_COUNT_EN
    assign count = occ;
`endif

endmodule
